// File: rtl/uninasoc_pkg.sv
// -----------------------------------------------------------------------------
// uninasoc_pkg
// Shared constants for the GPIO input controller: the default pin count,
// the register-bus address width, the register byte offsets, and a decode
// helper that turns a word index into a register selector.
// -----------------------------------------------------------------------------
package uninasoc_pkg;

    localparam int NUM_GPIO_IN            = 16;
    localparam int GPIO_IN_REG_ADDR_WIDTH = 5;

    localparam logic [GPIO_IN_REG_ADDR_WIDTH-1:0] GPIO_IN_DATA_OFFSET    = 5'h00;
    localparam logic [GPIO_IN_REG_ADDR_WIDTH-1:0] GPIO_IN_IRQ_EN_OFFSET  = 5'h04;
    localparam logic [GPIO_IN_REG_ADDR_WIDTH-1:0] GPIO_IN_RISE_EN_OFFSET = 5'h08;
    localparam logic [GPIO_IN_REG_ADDR_WIDTH-1:0] GPIO_IN_FALL_EN_OFFSET = 5'h0C;
    localparam logic [GPIO_IN_REG_ADDR_WIDTH-1:0] GPIO_IN_PENDING_OFFSET = 5'h10;

    typedef enum logic [2:0] {
        GPIO_IN_REG_DATA     = 3'd0,
        GPIO_IN_REG_IRQ_EN   = 3'd1,
        GPIO_IN_REG_RISE_EN  = 3'd2,
        GPIO_IN_REG_FALL_EN  = 3'd3,
        GPIO_IN_REG_PENDING  = 3'd4,
        GPIO_IN_REG_UNMAPPED = 3'd7
    } gpio_in_reg_e;

    // Word index is the byte address with the two byte-lane bits dropped.
    function automatic gpio_in_reg_e gpio_in_decode(
        input logic [GPIO_IN_REG_ADDR_WIDTH-3:0] word
    );
        gpio_in_reg_e sel;
        sel = GPIO_IN_REG_UNMAPPED;
        if      (word == GPIO_IN_DATA_OFFSET[GPIO_IN_REG_ADDR_WIDTH-1:2])    sel = GPIO_IN_REG_DATA;
        else if (word == GPIO_IN_IRQ_EN_OFFSET[GPIO_IN_REG_ADDR_WIDTH-1:2])  sel = GPIO_IN_REG_IRQ_EN;
        else if (word == GPIO_IN_RISE_EN_OFFSET[GPIO_IN_REG_ADDR_WIDTH-1:2]) sel = GPIO_IN_REG_RISE_EN;
        else if (word == GPIO_IN_FALL_EN_OFFSET[GPIO_IN_REG_ADDR_WIDTH-1:2]) sel = GPIO_IN_REG_FALL_EN;
        else if (word == GPIO_IN_PENDING_OFFSET[GPIO_IN_REG_ADDR_WIDTH-1:2]) sel = GPIO_IN_REG_PENDING;
        return sel;
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// -----------------------------------------------------------------------------
// gpio_debounce
// One input pin: SYNC_STAGES-deep synchroniser followed by a debouncer that
// accepts a new level only after it has differed from the accepted level for
// DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clock_i   - system clock, rising edge
//   reset_ni  - asynchronous active-low reset
//   pin_i     - raw asynchronous pin
//   stable_o  - debounced level
//   rise_o    - high in the cycle stable_o is about to go 0->1
//   fall_o    - high in the cycle stable_o is about to go 1->0
// -----------------------------------------------------------------------------
module gpio_debounce #(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clock_i,
    input  logic reset_ni,
    input  logic pin_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   stable_q;
    logic                   synced;
    logic                   update;

    assign synced = sync_q[SYNC_STAGES-1];
    // The counter has already seen DEBOUNCE_CYCLES-1 differing cycles, so this
    // differing cycle is the last one needed: accept the new level now.
    assign update = (synced != stable_q) && (cnt_q == CNT_LAST);

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            if (synced == stable_q) begin
                cnt_q <= '0;
            end else if (update) begin
                stable_q <= synced;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = update & synced;
    assign fall_o   = update & ~synced;

endmodule

// File: rtl/gpio_in_ctrl.sv
// -----------------------------------------------------------------------------
// gpio_in_ctrl
// Debounced GPIO input block with edge-detect interrupts and a small register
// interface.
// Register access handshake: reg_req_i is a one-cycle request; the access is
// performed at the next rising edge, and reg_ack_o is high for exactly the
// following cycle with reg_rdata_o holding read data (0 for writes and in all
// non-ack cycles). Write side effects are visible from the ack cycle on.
// Ports:
//   clock_i, reset_ni         - clock, asynchronous active-low reset
//   gpio_i[NUM_GPIO]          - raw asynchronous pins
//   reg_req_i/we_i/addr_i/wdata_i - register request
//   reg_rdata_o, reg_ack_o    - register response
//   irq_o                     - registered level interrupt
// -----------------------------------------------------------------------------
module gpio_in_ctrl
    import uninasoc_pkg::*;
#(
    parameter int NUM_GPIO        = NUM_GPIO_IN,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                              clock_i,
    input  logic                              reset_ni,
    input  logic [NUM_GPIO-1:0]               gpio_i,
    input  logic                              reg_req_i,
    input  logic                              reg_we_i,
    input  logic [GPIO_IN_REG_ADDR_WIDTH-1:0] reg_addr_i,
    input  logic [31:0]                       reg_wdata_i,
    output logic [31:0]                       reg_rdata_o,
    output logic                              reg_ack_o,
    output logic                              irq_o
);

    logic [NUM_GPIO-1:0] stable;
    logic [NUM_GPIO-1:0] rise;
    logic [NUM_GPIO-1:0] fall;
    logic [NUM_GPIO-1:0] irq_en_q;
    logic [NUM_GPIO-1:0] rise_en_q;
    logic [NUM_GPIO-1:0] fall_en_q;
    logic [NUM_GPIO-1:0] pending_q;
    logic [NUM_GPIO-1:0] pending_set;
    logic [NUM_GPIO-1:0] pending_clr;
    logic [NUM_GPIO-1:0] wdata;
    logic [31:0]         rd_data;
    gpio_in_reg_e        reg_sel;
    logic                wr_en;

    for (genvar i = 0; i < NUM_GPIO; i++) begin : g_pin
        gpio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_debounce (
            .clock_i (clock_i),
            .reset_ni(reset_ni),
            .pin_i   (gpio_i[i]),
            .stable_o(stable[i]),
            .rise_o  (rise[i]),
            .fall_o  (fall[i])
        );
    end

    // Data bits at and above NUM_GPIO have no storage and are simply dropped.
    if (NUM_GPIO < 32) begin : g_unused_wdata
        logic unused_wdata;
        assign unused_wdata = ^reg_wdata_i[31:NUM_GPIO];
    end
    logic unused_addr;
    assign unused_addr = ^reg_addr_i[1:0];

    assign wdata   = reg_wdata_i[NUM_GPIO-1:0];
    assign reg_sel = gpio_in_decode(reg_addr_i[GPIO_IN_REG_ADDR_WIDTH-1:2]);
    assign wr_en   = reg_req_i & reg_we_i;

    assign pending_set = (rise & rise_en_q) | (fall & fall_en_q);
    assign pending_clr = (wr_en && reg_sel == GPIO_IN_REG_PENDING) ? wdata : '0;

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            GPIO_IN_REG_DATA:    rd_data = 32'(stable);
            GPIO_IN_REG_IRQ_EN:  rd_data = 32'(irq_en_q);
            GPIO_IN_REG_RISE_EN: rd_data = 32'(rise_en_q);
            GPIO_IN_REG_FALL_EN: rd_data = 32'(fall_en_q);
            GPIO_IN_REG_PENDING: rd_data = 32'(pending_q);
            default:             rd_data = '0;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            irq_en_q    <= '0;
            rise_en_q   <= '0;
            fall_en_q   <= '0;
            pending_q   <= '0;
            irq_o       <= 1'b0;
            reg_ack_o   <= 1'b0;
            reg_rdata_o <= '0;
        end else begin
            // A new edge in the same cycle as a write-1-to-clear keeps the bit.
            pending_q <= (pending_q & ~pending_clr) | pending_set;
            irq_o     <= |(pending_q & irq_en_q);
            reg_ack_o <= reg_req_i;
            reg_rdata_o <= (reg_req_i && !reg_we_i) ? rd_data : 32'd0;
            if (wr_en) begin
                case (reg_sel)
                    GPIO_IN_REG_IRQ_EN:  irq_en_q  <= wdata;
                    GPIO_IN_REG_RISE_EN: rise_en_q <= wdata;
                    GPIO_IN_REG_FALL_EN: fall_en_q <= wdata;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gpio_in_ctrl.sv
module tb_gpio_in_ctrl;

    localparam int NUM_GPIO = 16;

    logic              clock_i;
    logic              reset_ni;
    logic [NUM_GPIO-1:0] gpio_i;
    logic              reg_req_i;
    logic              reg_we_i;
    logic [4:0]        reg_addr_i;
    logic [31:0]       reg_wdata_i;
    logic [31:0]       reg_rdata_o;
    logic              reg_ack_o;
    logic              irq_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    gpio_in_ctrl #(
        .NUM_GPIO       (NUM_GPIO),
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2)
    ) dut (
        .clock_i    (clock_i),
        .reset_ni   (reset_ni),
        .gpio_i     (gpio_i),
        .reg_req_i  (reg_req_i),
        .reg_we_i   (reg_we_i),
        .reg_addr_i (reg_addr_i),
        .reg_wdata_i(reg_wdata_i),
        .reg_rdata_o(reg_rdata_o),
        .reg_ack_o  (reg_ack_o),
        .irq_o      (irq_o)
    );

    // clock / reset
    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock_i);
        #1;
    endtask

    // driver tasks: called at posedge+1, return at the next posedge+1
    task automatic rd(input logic [4:0] addr, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
        reg_req_i  = 1'b1;
        reg_we_i   = 1'b0;
        reg_addr_i = addr;
        tick(1);
        reg_req_i  = 1'b0;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        reg_req_i   = 1'b1;
        reg_we_i    = 1'b1;
        reg_addr_i  = addr;
        reg_wdata_i = data;
        tick(1);
        reg_req_i   = 1'b0;
        reg_we_i    = 1'b0;
    endtask

    // monitor / scoreboard
    logic req_prev = 1'b0;
    logic we_prev  = 1'b0;
    always @(negedge clock_i) begin
        if (!reset_ni) begin
            check("ack_in_reset", {31'd0, reg_ack_o}, 32'd0);
            req_prev = 1'b0;
            we_prev  = 1'b0;
        end else begin
            if (req_prev || reg_ack_o)
                check("ack_timing", {31'd0, reg_ack_o}, {31'd0, req_prev});
            if (reg_ack_o && !we_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_read_ack", 32'd1, 32'd0);
                end else begin
                    check(name_q.pop_front(), reg_rdata_o, exp_q.pop_front());
                end
            end else begin
                check("rdata_idle_zero", reg_rdata_o, 32'd0);
            end
            req_prev = reg_req_i;
            we_prev  = reg_we_i;
        end
    end

    initial begin
        reset_ni    = 1'b0;
        gpio_i      = '0;
        reg_req_i   = 1'b0;
        reg_we_i    = 1'b0;
        reg_addr_i  = '0;
        reg_wdata_i = '0;
        tick(3);
        check("reset_irq", {31'd0, irq_o}, 32'd0);
        check("reset_ack", {31'd0, reg_ack_o}, 32'd0);
        check("reset_rdata", reg_rdata_o, 32'd0);
        reset_ni = 1'b1;
        tick(2);

        rd(5'h00, 32'h0, "rst_data");
        rd(5'h04, 32'h0, "rst_irq_en");
        rd(5'h08, 32'h0, "rst_rise_en");
        rd(5'h0C, 32'h0, "rst_fall_en");
        rd(5'h10, 32'h0, "rst_pending");

        // 3-cycle glitch on bit 3 must be rejected
        wr(5'h08, 32'h8);
        wr(5'h0C, 32'h8);
        wr(5'h04, 32'h8);
        gpio_i[3] = 1'b1;
        tick(3);
        gpio_i[3] = 1'b0;
        tick(10);
        check("glitch_irq", {31'd0, irq_o}, 32'd0);
        rd(5'h00, 32'h0, "glitch_data");
        rd(5'h10, 32'h0, "glitch_pending");

        // 4-cycle pulse is exactly long enough: rise then fall accepted
        gpio_i[3] = 1'b1;
        tick(4);
        gpio_i[3] = 1'b0;
        tick(12);
        check("pulse4_irq", {31'd0, irq_o}, 32'd1);
        rd(5'h00, 32'h0, "pulse4_data");
        rd(5'h10, 32'h8, "pulse4_pending");
        wr(5'h10, 32'h8);
        tick(2);
        check("pulse4_irq_cleared", {31'd0, irq_o}, 32'd0);
        rd(5'h10, 32'h0, "pulse4_pending_cleared");
        wr(5'h08, 32'h0);
        wr(5'h0C, 32'h0);
        wr(5'h04, 32'h0);

        // rising edge on bit 0: stable at +6, irq at +7
        wr(5'h08, 32'h1);
        wr(5'h04, 32'h1);
        gpio_i[0] = 1'b1;
        tick(6);
        check("rise_irq_early", {31'd0, irq_o}, 32'd0);
        tick(1);
        check("rise_irq", {31'd0, irq_o}, 32'd1);
        rd(5'h00, 32'h1, "rise_data");
        rd(5'h10, 32'h1, "rise_pending");

        // falling edge on bit 15, then W1C drops irq one cycle later
        wr(5'h10, 32'h1);
        wr(5'h0C, 32'h8000);
        wr(5'h04, 32'h8000);
        gpio_i[15] = 1'b1;
        tick(8);
        gpio_i[15] = 1'b0;
        tick(8);
        check("fall_irq", {31'd0, irq_o}, 32'd1);
        rd(5'h10, 32'h8000, "fall_pending");
        rd(5'h00, 32'h1, "fall_data");
        wr(5'h10, 32'h8000);
        check("w1c_irq_hold", {31'd0, irq_o}, 32'd1);
        tick(1);
        check("w1c_irq_drop", {31'd0, irq_o}, 32'd0);
        rd(5'h10, 32'h0, "w1c_pending");

        // set wins over same-cycle W1C on bit 2
        wr(5'h08, 32'h5);
        wr(5'h0C, 32'h8004);
        gpio_i[2] = 1'b1;
        tick(8);
        rd(5'h10, 32'h4, "bit2_rise_pending");
        gpio_i[2] = 1'b0;
        tick(5);
        wr(5'h10, 32'h4);
        rd(5'h10, 32'h4, "set_wins");
        wr(5'h10, 32'h4);
        rd(5'h10, 32'h0, "bit2_cleared");

        // width masking, unmapped addresses, read-only DATA, ignored addr[1:0]
        wr(5'h04, 32'hFFFF_FFFF);
        rd(5'h04, 32'h0000_FFFF, "irq_en_mask");
        rd(5'h18, 32'h0, "unmapped_18");
        wr(5'h14, 32'h1234);
        rd(5'h14, 32'h0, "unmapped_14");
        rd(5'h1C, 32'h0, "unmapped_1c");
        wr(5'h00, 32'hFFFF);
        rd(5'h00, 32'h1, "data_ro");
        rd(5'h0B, 32'h5, "addr_lsb_ignored");

        // reset mid-debounce and mid-access
        gpio_i[15] = 1'b1;
        tick(3);
        reg_req_i   = 1'b1;
        reg_we_i    = 1'b1;
        reg_addr_i  = 5'h04;
        reg_wdata_i = 32'h0;
        reset_ni    = 1'b0;
        tick(1);
        check("midrst_irq", {31'd0, irq_o}, 32'd0);
        reg_req_i = 1'b0;
        reg_we_i  = 1'b0;
        reset_ni  = 1'b1;
        rd(5'h00, 32'h0, "post_rst_data");
        rd(5'h04, 32'h0, "post_rst_irq_en");
        rd(5'h08, 32'h0, "post_rst_rise_en");
        rd(5'h0C, 32'h0, "post_rst_fall_en");
        rd(5'h10, 32'h0, "post_rst_pending");
        check("post_rst_irq", {31'd0, irq_o}, 32'd0);
        tick(10);
        rd(5'h00, 32'h8001, "post_rst_data_settled");
        rd(5'h10, 32'h0, "post_rst_no_pending");
        tick(3);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpio_in_ctrl.md
GPIO_IN_CTRL -- requirements
Module: gpio_in_ctrl

Interface
REQ-001 SHALL have parameter NUM_GPIO, default uninasoc_pkg::NUM_GPIO_IN (16), number of input pins, legal 1..32.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1024, stable-cycle count before a pin change is accepted, legal >=1.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth, legal >=2.
REQ-004 SHALL have clock_i  input  1  single system clock, all logic on rising edge.
REQ-005 SHALL have reset_ni  input  1  asynchronous, active-low reset.
REQ-006 SHALL have gpio_i  input  NUM_GPIO  asynchronous external pins.
REQ-007 SHALL have reg_req_i  input  1  register access request, one-cycle pulse.
REQ-008 SHALL have reg_we_i  input  1  1 = write, 0 = read, qualified by reg_req_i.
REQ-009 SHALL have reg_addr_i  input  5  byte address, word aligned, addr[1:0] ignored.
REQ-010 SHALL have reg_wdata_i  input  32  write data.
REQ-011 SHALL have reg_rdata_o  output  32  read data, valid with reg_ack_o.
REQ-012 SHALL have reg_ack_o  output  1  access completion pulse.
REQ-013 SHALL have irq_o  output  1  level interrupt, registered.

Function
REQ-014 SHALL pass each gpio_i bit through a SYNC_STAGES flop chain before any other use.
REQ-015 SHALL keep, per bit, a stable value and a debounce counter of width $clog2(DEBOUNCE_CYCLES+1).
REQ-016 Per bit: synced == stable -> counter cleared; synced != stable -> counter increments; when counter == DEBOUNCE_CYCLES-1 and still differing, stable <= synced and counter cleared in the same cycle.
REQ-017 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL never change stable; DEBOUNCE_CYCLES=1 SHALL update stable one cycle after synced changes.
REQ-018 Register map: 0x00 DATA (RO, stable), 0x04 IRQ_EN (RW), 0x08 RISE_EN (RW), 0x0C FALL_EN (RW), 0x10 PENDING (RO, write-1-to-clear).
REQ-019 A rising stable transition with RISE_EN[i]=1, or a falling one with FALL_EN[i]=1, SHALL set PENDING[i] in the cycle stable updates.
REQ-020 Same-cycle set and W1C of one PENDING bit: set SHALL win.
REQ-021 irq_o SHALL equal registered |(PENDING & IRQ_EN), one cycle after PENDING/IRQ_EN change.
REQ-022 reg_ack_o SHALL pulse exactly one cycle after each reg_req_i; reg_rdata_o valid in that cycle, 0 otherwise.
REQ-023 Register bits at and above NUM_GPIO SHALL read 0 and ignore writes.
REQ-024 Unmapped addresses 0x14-0x1C: read returns 0, write ignored, ack still issued.
REQ-025 Writes to DATA SHALL be ignored; register writes take effect on the ack cycle.

Reset
REQ-026 Reset SHALL clear synchroniser flops, stable, counters, IRQ_EN, RISE_EN, FALL_EN, PENDING, irq_o, reg_ack_o, reg_rdata_o to 0.
REQ-027 Reset mid-debounce or mid-access SHALL abandon it: no ack, no pending set after release.
REQ-028 After release, a pin already high SHALL produce a rising event after SYNC_STAGES+DEBOUNCE_CYCLES cycles (stable resets to 0).

Structure
REQ-029 Register offsets and GPIO_IN_REG_ADDR_WIDTH (5) SHALL be constants in uninasoc_pkg; NUM_GPIO default from uninasoc_pkg::NUM_GPIO_IN.
REQ-030 Per-bit synchroniser plus debounce SHALL be sub-module gpio_debounce, instantiated NUM_GPIO times via generate.

Verification
REQ-031 DEBOUNCE_CYCLES=4, RISE_EN=0x1, IRQ_EN=0x1; gpio_i[0] 0->1 held -> DATA[0]=1 and irq_o=1 after 2+4+1 cycles; PENDING=0x1.
REQ-032 DEBOUNCE_CYCLES=4; gpio_i[3] 3-cycle high pulse -> DATA and PENDING remain 0x0000, irq_o stays 0.
REQ-033 FALL_EN=0x8000; bit 15 settles 1 then 0 -> PENDING=0x8000 only; write PENDING 0x8000 -> reads 0, irq_o drops next cycle.
REQ-034 Force new edge on bit 2 in the same cycle as W1C of PENDING[2] -> PENDING[2] reads 1.
REQ-035 NUM_GPIO=16: write 0xFFFFFFFF to IRQ_EN -> reads 0x0000FFFF; read 0x18 -> 0 with ack one cycle later.
REQ-036 Assert reset_ni low for 1 cycle mid-debounce with registers programmed -> all registers read 0, irq_o=0, no spurious ack.
